// File: rtl/hid_kbd_pkg.sv
// HID keyboard constants, FSM state type and the ASCII-to-usage lookup
// shared by the ASCII keyer and its sub-blocks.
package hid_kbd_pkg;

  localparam logic [7:0] HID_A      = 8'h04;
  localparam logic [7:0] HID_1      = 8'h1E;
  localparam logic [7:0] HID_0      = 8'h27;
  localparam logic [7:0] HID_ENTER  = 8'h28;
  localparam logic [7:0] HID_TAB    = 8'h2B;
  localparam logic [7:0] HID_SPACE  = 8'h2C;
  localparam logic [7:0] HID_MINUS  = 8'h2D;
  localparam logic [7:0] HID_COMMA  = 8'h36;
  localparam logic [7:0] HID_DOT    = 8'h37;

  localparam logic [7:0] MOD_NONE   = 8'h00;
  localparam logic [7:0] MOD_LSHIFT = 8'h02;

  typedef enum logic [1:0] {IDLE, CONV, PULSE, GAP} kbd_state_e;

  typedef struct packed {
    logic       mapped;
    logic [7:0] modifier;
    logic [7:0] usage;
  } hid_key_t;

  // Letters and digits map by offset from their first usage; the rest are singles.
  function automatic hid_key_t ascii_to_hid(input logic [7:0] c);
    hid_key_t k;
    k.mapped   = 1'b1;
    k.modifier = MOD_NONE;
    k.usage    = 8'h00;
    if (c inside {[8'h61:8'h7A]}) begin
      k.usage = HID_A + (c - 8'h61);
    end else if (c inside {[8'h41:8'h5A]}) begin
      k.usage    = HID_A + (c - 8'h41);
      k.modifier = MOD_LSHIFT;
    end else if (c inside {[8'h31:8'h39]}) begin
      k.usage = HID_1 + (c - 8'h31);
    end else begin
      case (c)
        8'h30:        k.usage = HID_0;
        8'h0A, 8'h0D: k.usage = HID_ENTER;
        8'h09:        k.usage = HID_TAB;
        8'h20:        k.usage = HID_SPACE;
        8'h2D:        k.usage = HID_MINUS;
        8'h5F: begin
          k.usage    = HID_MINUS;
          k.modifier = MOD_LSHIFT;
        end
        8'h2C:        k.usage = HID_COMMA;
        8'h2E:        k.usage = HID_DOT;
        default:      k.mapped = 1'b0;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/hid_char_fifo.sv
// Synchronous byte FIFO, depth 2**AW, registered read data valid the cycle
// after a pop.
// Ports: clk, rstn (async active-low), wr_en/wr_data push, rd_en pop,
//        rd_data registered head byte, full_c/empty_c combinational flags.
module hid_char_fifo #(
  parameter int unsigned AW = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full_c,
  output logic       empty_c
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_wr;
  logic        do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr   = wr_en && !full_c;
  assign do_rd   = rd_en && !empty_c;

  // Pointers and read register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= 8'h00;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) begin
        rd_ptr  <= rd_ptr + (AW+1)'(1);
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/hid_ascii_keyer.sv
// Buffers ASCII bytes and types them into usb_hid_top as one paced
// key_request pulse per mappable character.
// Ports: rstn/clk; in_data/in_valid/in_ready byte stream (in_ready = !full);
//        key_value {modifier, usage} and key_request pulse to usb_hid_top;
//        busy (work queued or in flight); unmapped_cnt saturating drop count.
module hid_ascii_keyer
  import hid_kbd_pkg::*;
#(
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned GAP_CYCLES = 600000
) (
  input  logic        rstn,
  input  logic        clk,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] key_value,
  output logic        key_request,
  output logic        busy,
  output logic [7:0]  unmapped_cnt
);

  localparam int unsigned GW = 24;
  // IDLE->CONV->PULSE costs three cycles, so GAP holds for the remainder.
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 3);

  kbd_state_e    state;
  kbd_state_e    state_next;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_cnt_next;
  logic [15:0]   key_value_next;
  logic          key_request_next;
  logic [7:0]    unmapped_next;
  logic          pop;
  logic [7:0]    head_byte;
  logic          full_c;
  logic          empty_c;
  hid_key_t      conv_key;

  assign in_ready = !full_c;

  hid_char_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (head_byte),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      gap_cnt      <= '0;
      key_value    <= 16'h0000;
      key_request  <= 1'b0;
      unmapped_cnt <= 8'h00;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      gap_cnt      <= gap_cnt_next;
      key_value    <= key_value_next;
      key_request  <= key_request_next;
      unmapped_cnt <= unmapped_next;
      busy         <= !empty_c || (state != IDLE);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next       = state;
    gap_cnt_next     = gap_cnt;
    key_value_next   = key_value;
    key_request_next = 1'b0;
    unmapped_next    = unmapped_cnt;
    pop              = 1'b0;
    conv_key         = ascii_to_hid(head_byte);
    case (state)
      IDLE: begin
        if (!empty_c && (gap_cnt == '0)) begin
          pop        = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        if (conv_key.mapped) begin
          key_value_next   = {conv_key.modifier, conv_key.usage};
          key_request_next = 1'b1;
          state_next       = PULSE;
        end else begin
          if (unmapped_cnt != 8'hFF) unmapped_next = unmapped_cnt + 8'd1;
          state_next = IDLE;
        end
      end
      PULSE: begin
        gap_cnt_next = GAP_LOAD;
        state_next   = GAP;
      end
      GAP: begin
        if (gap_cnt <= GW'(1)) begin
          gap_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          gap_cnt_next = gap_cnt - GW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/hid_ascii_keyer.md
Name: hid_ascii_keyer

Overview:
- Upstream feeder for usb_hid_top. Accepts ASCII bytes over a valid/ready stream and buffers them in a small FIFO.
- Translates each byte to an HID keyboard usage plus modifier. Drives usb_hid_top's key_value/key_request pair with one request pulse per character, paced by a fixed gap.
- Replaces the free-running counter stimulus in the top level with a "type this text" path. Typical sources are the CDC receive path or a ROM string walker.

Parameters:
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW bytes.
- GAP_CYCLES, 600000, clk cycles between consecutive key_request pulses (10 ms at 60 MHz); legal range 4..2**24-1.

Ports:
- rstn  input  1  asynchronous active-low reset
- clk  input  1  single clock (60 MHz in the target design); all logic on posedge clk
- in_data  input  8  ASCII byte
- in_valid  input  1  in_data valid
- in_ready  output  1  FIFO not full; byte accepted on edge where in_valid & in_ready
- key_value  output  16  [15:8] HID modifier byte, [7:0] HID usage ID; to usb_hid_top.key_value
- key_request  output  1  one-cycle pulse per typed key; to usb_hid_top.key_request
- busy  output  1  FIFO non-empty or FSM not IDLE
- unmapped_cnt  output  8  count of dropped unmappable bytes, saturates at 255

Behaviour:
- Reset (rstn=0, async):
  - key_value = 16'h0000, key_request = 0, unmapped_cnt = 0.
  - FIFO emptied, so in_ready = 1 and busy = 0 once reset is sampled low.
  - FSM goes to IDLE and the gap counter clears.
  - Reset mid-operation discards all buffered bytes and any pending pulse.
- FIFO behaviour:
  - in_ready = !full, combinational from FIFO state.
  - A write while full is impossible by handshake; in_valid with in_ready=0 is held by the source.
  - Simultaneous write and read are both performed; the count is unchanged.
- FSM states:
  - IDLE: if FIFO non-empty and gap expired, pop and go to CONV.
  - CONV: popped byte is present; look it up.
    - Mapped: register key_value, assert key_request next cycle, go to PULSE.
    - Unmapped: increment unmapped_cnt (saturating), leave key_value unchanged, no pulse, go to IDLE with no gap charged.
  - PULSE: key_request = 1 for exactly this cycle; start the gap counter; go to GAP.
  - GAP: wait until the next pulse may land exactly GAP_CYCLES cycles after the previous one; then go to IDLE.
- Latency: a byte accepted at edge N with an empty FIFO and no gap pending gives key_request = 1 during cycle N+3.
- Pacing: with a backlogged FIFO, consecutive key_request rising edges are exactly GAP_CYCLES cycles apart.
- key_value is stable from the key_request cycle until the next mapped character.
- Mapping (modifier 8'h02 = left shift, else 8'h00):
  - 'a'..'z' -> 04..1D
  - 'A'..'Z' -> 04..1D with shift
  - '1'..'9' -> 1E..26
  - '0' -> 27
  - 0x0A, 0x0D -> 28
  - 0x09 -> 2B
  - ' ' -> 2C
  - '-' -> 2D; '_' -> 2D with shift
  - ',' -> 36
  - '.' -> 37
  - all other bytes unmapped.
- busy deasserts in the cycle after the FSM returns to IDLE with the FIFO empty; the trailing GAP counts as busy.

Decomposition:
- Package hid_kbd_pkg holds:
  - usage constants (HID_A, HID_1, HID_0, HID_ENTER, HID_TAB, HID_SPACE, HID_MINUS, HID_COMMA, HID_DOT);
  - MOD_LSHIFT = 8'h02;
  - the FSM state enum {IDLE, CONV, PULSE, GAP};
  - a pure function ascii_to_hid(byte) returning {mapped, modifier, usage}.
- Sub-module hid_char_fifo: synchronous FIFO, parameter AW, registered read data valid the cycle after pop, with full/empty flags and async active-low reset.

Test Plan:
- Reset then single byte 8'h61 ('a') at edge N -> key_request high only in cycle N+3, key_value = 16'h0004; busy drops after GAP_CYCLES.
- GAP_CYCLES=8, burst "Hi0\n" (48 69 30 0A) -> four pulses 8 cycles apart with key_value 0x020B, 0x000C, 0x0027, 0x0028.
- FIFO_AW=2, push 6 bytes back-to-back while pacing -> in_ready low after 4 unpopped bytes; no byte lost or duplicated; output order preserved.
- Bytes 0x7E, 0x00, 'b' -> unmapped_cnt = 2; single pulse with key_value 0x0005, issued with no extra gap for the dropped bytes; 300 unmapped bytes -> unmapped_cnt holds 255.
- rstn pulsed low mid-GAP with 3 bytes queued -> outputs return to reset values immediately; no further key_request; next byte after release follows N+3 latency.
- Simultaneous push and pop with FIFO at depth-1 -> in_ready stays 1; count unchanged; data integrity checked against a scoreboard.
